// File: rtl/wigend_in.sv
// wigend_in: Wiegand-26 receiver with glitch rejection, gap-based frame end, length and parity checks.
// The interrupt level output is named intr because int is a reserved word.
module wigend_in #(
   parameter int FRAME_BITS = 26,
   parameter int MIN_PULSE  = 100,
   parameter int MAX_PULSE  = 1000,
   parameter int FRAME_GAP  = 5000,
   parameter int PARITY_CHK = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            wigend,
   output logic [FRAME_BITS-1:0] data,
   output logic                  frame_done,
   output logic [2:0]            err,
   output logic                  intr,
   input  logic                  int_clr
);
   localparam int WW = $clog2(MAX_PULSE + 2);
   localparam int GW = $clog2(FRAME_GAP + 1);
   localparam int H  = FRAME_BITS / 2;
   localparam logic [WW-1:0] W_MIN = WW'(MIN_PULSE);
   localparam logic [WW-1:0] W_MAX = WW'(MAX_PULSE);
   localparam logic [GW-1:0] G_END = GW'(FRAME_GAP - 1);
   localparam logic [4:0]    N_BITS = 5'(FRAME_BITS);

   typedef enum logic [2:0] {IDLE, PULSE, STUCK, GAP, DONE} state_t;

   state_t                state;
   logic [1:0]            s1, s;
   logic [WW-1:0]         wcnt;
   logic [GW-1:0]         gcnt;
   logic [4:0]            bit_cnt;
   logic [FRAME_BITS-1:0] shift;
   logic                  bit_val, pflag;
   logic                  len_bad, par_bad;

   // even parity over the upper half, odd parity over the lower half
   assign len_bad = bit_cnt != N_BITS;
   assign par_bad = (PARITY_CHK != 0) && ((^shift[FRAME_BITS-1:H]) || !(^shift[H-1:0]));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         s1         <= '0;
         s          <= '0;
         wcnt       <= '0;
         gcnt       <= '0;
         bit_cnt    <= '0;
         shift      <= '0;
         bit_val    <= 1'b0;
         pflag      <= 1'b0;
         data       <= '0;
         frame_done <= 1'b0;
         err        <= '0;
         intr       <= 1'b0;
      end else begin
         s1         <= wigend;
         s          <= s1;
         frame_done <= 1'b0;
         if (int_clr) intr <= 1'b0;
         case (state)
            IDLE: if (s != 2'b00) begin
               state   <= PULSE;
               wcnt    <= WW'(1);
               bit_val <= s[1];
            end
            PULSE: if (s != 2'b00) begin
               pflag <= pflag | (&s);
               wcnt  <= wcnt + 1'b1;
               if (wcnt == W_MAX) begin
                  pflag <= 1'b1;
                  state <= STUCK;
               end
            end else if (wcnt < W_MIN) begin
               // glitch: drop it, gap count resumes where it was
               state <= (bit_cnt == 5'd0) ? IDLE : GAP;
            end else begin
               shift   <= {shift[FRAME_BITS-2:0], bit_val};
               bit_cnt <= bit_cnt + 5'(bit_cnt != 5'd31);
               gcnt    <= '0;
               state   <= GAP;
            end
            STUCK: if (s == 2'b00) begin
               gcnt  <= '0;
               state <= GAP;
            end
            GAP: if (s != 2'b00) begin
               state   <= PULSE;
               wcnt    <= WW'(1);
               bit_val <= s[1];
            end else if (gcnt == G_END) state <= DONE;
            else gcnt <= gcnt + 1'b1;
            DONE: begin
               err        <= {par_bad, len_bad, pflag};
               frame_done <= 1'b1;
               if (!par_bad && !len_bad && !pflag) begin
                  data <= shift;
                  intr <= 1'b1;
               end
               shift   <= '0;
               bit_cnt <= '0;
               pflag   <= 1'b0;
               gcnt    <= '0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wigend_in.sv
// tb_wigend_in: scoreboard bench for the Wiegand-26 receiver, timings scaled down by 10.
module tb_wigend_in;
   localparam int MINP = 10, MAXP = 100, GAPC = 500, PW = 50, LW = 170;

   logic        clk = 1'b0, rst = 1'b0, int_clr = 1'b0, frame_done, intr;
   logic [1:0]  wig = 2'b00;
   logic [25:0] data;
   logic [2:0]  err;
   int          tests = 0, fails = 0;

   typedef struct {logic [2:0] err; logic [25:0] data; logic intr;} exp_t;
   exp_t q[$];

   wigend_in #(.FRAME_BITS(26), .MIN_PULSE(MINP), .MAX_PULSE(MAXP), .FRAME_GAP(GAPC), .PARITY_CHK(1)) dut (
      .clk(clk), .rst(rst), .wigend(wig), .data(data), .frame_done(frame_done),
      .err(err), .intr(intr), .int_clr(int_clr));

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [2:0] e, input logic [25:0] d, input logic i);
      exp_t x;
      x.err = e; x.data = d; x.intr = i;
      q.push_back(x);
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // bits go out MSB first; optional collision, glitch and stuck pulse at given bit positions
   task automatic send(input logic [31:0] w, input int n, input int coll = -1, input int glitch = -1, input int stuck = -1);
      for (int i = 0; i < n; i++) begin
         logic b;
         b = w[n-1-i];
         wig = (i == coll) ? 2'b11 : {b, ~b};
         clocks(PW);
         wig = 2'b00;
         clocks(LW);
         if (i == glitch) begin
            wig = 2'b01; clocks(5); wig = 2'b00; clocks(LW);
         end
         if (i == stuck) begin
            wig = 2'b10; clocks(300); wig = 2'b00; clocks(LW);
         end
      end
   endtask

   task automatic pulse_clr();
      int_clr = 1'b1; clocks(1); int_clr = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst && frame_done) begin
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_frame_done: got err %b data %h expected none", err, data);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("err", 32'(err), 32'(e.err));
            check("data", 32'(data), 32'(e.data));
            check("intr", 32'(intr), 32'(e.intr));
         end
      end
   end

   initial begin
      clocks(3);
      check("rst_data", 32'(data), 0);
      check("rst_err", 32'(err), 0);
      check("rst_intr", 32'(intr), 0);
      check("rst_done", 32'(frame_done), 0);
      rst = 1'b1;
      clocks(5);
      push(3'b000, 26'h3000001, 1'b1); send(32'h3000001, 26); clocks(GAPC + 40);
      pulse_clr();
      check("intr_clr1", 32'(intr), 0);
      push(3'b100, 26'h3000001, 1'b0); send(32'h2000001, 26); clocks(GAPC + 40);
      push(3'b010, 26'h3000001, 1'b0); send(32'h1800001, 25); clocks(GAPC + 40);
      push(3'b010, 26'h3000001, 1'b0); send(32'h3000001, 27); clocks(GAPC + 40);
      push(3'b000, 26'h3000001, 1'b1); send(32'h3000001, 26, -1, 10); clocks(GAPC + 40);
      push(3'b101, 26'h3000001, 1'b1); send(32'h3000001, 26, 5); clocks(GAPC + 40);
      push(3'b001, 26'h3000001, 1'b1); send(32'h3000001, 26, -1, -1, 5); clocks(GAPC + 40);
      push(3'b000, 26'h3000001, 1'b1); send(32'h3000001, 26); clocks(GAPC + 40);
      send(32'h3000001, 13);
      rst = 1'b0;
      clocks(3);
      check("rst2_data", 32'(data), 0);
      check("rst2_err", 32'(err), 0);
      check("rst2_intr", 32'(intr), 0);
      check("rst2_done", 32'(frame_done), 0);
      rst = 1'b1;
      clocks(5);
      push(3'b000, 26'h3000001, 1'b1); send(32'h3000001, 26); clocks(GAPC + 40);
      pulse_clr();
      check("intr_clr2", 32'(intr), 0);
      check("pending_frames", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
